// File: rtl/i2c_master_seq.sv
// Byte-level I2C master: START/WRITE/READ/STOP commands become open-drain SCL/SDA sequences.
// Latency 4*CLK_DIV_Q (START/STOP) or 36*CLK_DIV_Q (WRITE/READ) plus any stretch; cmd_ready only while IDLE.
module i2c_master_seq #(
  parameter int CLK_DIV_Q = 125
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] wr_data,
  input  logic       rd_ack_n,
  output logic [7:0] rd_data,
  output logic       ack_err,
  output logic       done,
  output logic       busy,
  output logic       scl_t,
  output logic       sda_t,
  input  logic       scl_i,
  input  logic       sda_i
);

  localparam int            CW   = $clog2(CLK_DIV_Q);
  localparam logic [CW-1:0] QMAX = CW'(CLK_DIV_Q - 1);

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          is_read_q, is_read_d;
  logic          ack_bit_q, ack_bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          ack_err_q, ack_err_d;
  logic          done_q, done_d;
  logic          scl_t_q, scl_t_d;
  logic          sda_t_q, sda_t_d;

  logic accept, stall, q_wrap, sample, slot_end;

  always_comb begin
    accept   = (state_q == S_IDLE) && cmd_valid;
    // A target holding SCL low while we release it freezes the quarter counter.
    stall    = (state_q != S_IDLE) && (phase_q == 2'd1) && scl_t_q && !scl_i;
    q_wrap   = (state_q != S_IDLE) && !stall && (qcnt_q == QMAX);
    sample   = q_wrap && (phase_q == 2'd2);
    slot_end = q_wrap && (phase_q == 2'd3);

    state_d   = state_q;
    qcnt_d    = qcnt_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    is_read_d = is_read_q;
    ack_bit_d = ack_bit_q;
    shreg_d   = shreg_q;
    rd_data_d = rd_data_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;

    if (accept) begin
      qcnt_d    = '0;
      phase_d   = 2'd0;
      bit_cnt_d = 4'd0;
      is_read_d = (cmd == CMD_READ);
      ack_bit_d = rd_ack_n;
      shreg_d   = wr_data;
      case (cmd)
        CMD_START: begin
          state_d   = S_START;
          ack_err_d = 1'b0;
        end
        CMD_WRITE, CMD_READ: state_d = S_DATA;
        default:             state_d = S_STOP;
      endcase
    end else if (state_q != S_IDLE) begin
      if (!stall) begin
        qcnt_d = q_wrap ? '0 : qcnt_q + 1'b1;
      end
      if (q_wrap) begin
        phase_d = phase_q + 2'd1;
      end
      if (sample && (state_q == S_DATA)) begin
        if (bit_cnt_q == 4'd8) begin
          if (!is_read_q) begin
            ack_err_d = sda_i;
          end
        end else if (is_read_q) begin
          shreg_d = {shreg_q[6:0], sda_i};
        end
      end
      if (slot_end) begin
        if ((state_q == S_DATA) && (bit_cnt_q != 4'd8)) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (!is_read_q) begin
            shreg_d = {shreg_q[6:0], 1'b0};
          end
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if ((state_q == S_DATA) && is_read_q) begin
            rd_data_d = shreg_q;
          end
        end
      end
    end

    // Line levels are derived from the upcoming phase so the pins change on the phase boundary.
    scl_t_d = scl_t_q;
    sda_t_d = sda_t_q;
    case (state_d)
      S_START: begin
        scl_t_d = (phase_d == 2'd0) ? scl_t_q : (phase_d != 2'd3);
        sda_t_d = (phase_d == 2'd0) || (phase_d == 2'd1);
      end
      S_DATA: begin
        scl_t_d = (phase_d == 2'd1) || (phase_d == 2'd2);
        if (bit_cnt_d == 4'd8) begin
          sda_t_d = is_read_d ? ack_bit_d : 1'b1;
        end else begin
          sda_t_d = is_read_d ? 1'b1 : shreg_d[7];
        end
      end
      S_STOP: begin
        scl_t_d = (phase_d != 2'd0);
        sda_t_d = phase_d[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      qcnt_q    <= '0;
      phase_q   <= 2'd0;
      bit_cnt_q <= 4'd0;
      is_read_q <= 1'b0;
      ack_bit_q <= 1'b1;
      shreg_q   <= 8'h00;
      rd_data_q <= 8'h00;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
      scl_t_q   <= 1'b1;
      sda_t_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      is_read_q <= is_read_d;
      ack_bit_q <= ack_bit_d;
      shreg_q   <= shreg_d;
      rd_data_q <= rd_data_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
      scl_t_q   <= scl_t_d;
      sda_t_q   <= sda_t_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign rd_data   = rd_data_q;
  assign ack_err   = ack_err_q;
  assign scl_t     = scl_t_q;
  assign sda_t     = sda_t_q;

endmodule

// File: tb/tb_i2c_master_seq.sv
// Bench for i2c_master_seq: bus monitor decodes START/STOP and bit values at SCL rises,
// a target model drives ACK/read data, and expectations come from byte-level rules.
`timescale 1ns/1ps
module tb_i2c_master_seq;

  localparam int Q = 4;
  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  logic       CLK = 1'b0;
  logic       rst, cmd_valid, cmd_ready, rd_ack_n;
  logic [1:0] cmd;
  logic [7:0] wr_data, rd_data;
  logic       ack_err, done, busy, scl_t, sda_t, scl_i, sda_i;

  logic       stretch;
  logic [8:0] tgt_v;
  int         fall_base, rise_base, start_base, stop_base;
  int         fall_cnt = 0, rise_cnt = 0, start_cnt = 0, stop_cnt = 0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic       mon_line [1024];
  logic       mon_mst  [1024];
  int         tgt_idx;
  logic       tgt_bit;
  logic [7:0] exp_rd;
  int         total = 0, bad = 0;

  always #5 CLK = ~CLK;

  i2c_master_seq #(.CLK_DIV_Q(Q)) dut (
    .CLK(CLK), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .wr_data(wr_data), .rd_ack_n(rd_ack_n), .rd_data(rd_data), .ack_err(ack_err),
    .done(done), .busy(busy), .scl_t(scl_t), .sda_t(sda_t), .scl_i(scl_i), .sda_i(sda_i)
  );

  // Target: bit k of tgt_v is presented during data slot k (slots counted by SCL falls).
  assign tgt_idx = fall_cnt - fall_base;
  assign tgt_bit = (tgt_idx >= 0 && tgt_idx < 9) ? tgt_v[tgt_idx[3:0]] : 1'b1;
  assign scl_i   = scl_t & ~stretch;
  assign sda_i   = sda_t & tgt_bit;

  always @(negedge CLK) begin
    prev_scl <= scl_i;
    prev_sda <= sda_i;
    if (!prev_scl && scl_i) begin
      mon_line[rise_cnt % 1024] <= sda_i;
      mon_mst[rise_cnt % 1024]  <= sda_t;
      rise_cnt <= rise_cnt + 1;
    end
    if (prev_scl && !scl_i) fall_cnt <= fall_cnt + 1;
    if (prev_scl && scl_i && prev_sda && !sda_i) start_cnt <= start_cnt + 1;
    if (prev_scl && scl_i && !prev_sda && sda_i) stop_cnt <= stop_cnt + 1;
  end

  task automatic run_cmd(input logic [1:0] c, input logic [7:0] wd, input logic rack,
                         input logic [8:0] tv, input int st_at, input int st_len,
                         output int lat, output logic again, output logic [7:0] mid_rd,
                         output logic [1:0] rb);
    @(posedge CLK); #1;
    cmd_valid = 1'b1; cmd = c; wr_data = wd; rd_ack_n = rack;
    @(posedge CLK); #1;
    cmd_valid = 1'b0; cmd = 2'($urandom); wr_data = 8'($urandom); rd_ack_n = 1'($urandom);
    fall_base = fall_cnt; rise_base = rise_cnt; start_base = start_cnt; stop_base = stop_cnt;
    tgt_v = tv;
    lat = -1; again = 1'b0; mid_rd = rd_data; rb = 2'b00;
    for (int n = 1; n <= 400; n++) begin
      @(posedge CLK); #1;
      if (n == st_at) stretch = 1'b1;
      if (n == st_at + st_len) stretch = 1'b0;
      @(negedge CLK);
      if (n == 136) mid_rd = rd_data;
      if (done === 1'b1) begin
        lat = n;
        rb = {cmd_ready, busy};
        break;
      end
    end
    stretch = 1'b0;
    @(negedge CLK);
    again = done;
    #1;
    tgt_v = 9'h1FF;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total++; if (scl_t !== 1'b1) begin bad++; $display("FAIL reset_scl_t: got %b want 1", scl_t); end
    total++; if (sda_t !== 1'b1) begin bad++; $display("FAIL reset_sda_t: got %b want 1", sda_t); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL reset_ack_err: got %b want 0", ack_err); end
    exp_rd = 8'h00;
    rst = 1'b1;
  endtask

  task automatic test_start_stop();
    int lat; logic again; logic [7:0] mid; logic [1:0] rb;
    run_cmd(CMD_START, 8'h00, 1'b1, 9'h1FF, 0, 0, lat, again, mid, rb);
    total++; if (lat != 4*Q) begin bad++; $display("FAIL start_latency: got %0d want %0d", lat, 4*Q); end
    total++; if (start_cnt - start_base != 1) begin bad++; $display("FAIL start_condition: got %0d want 1", start_cnt - start_base); end
    total++; if (rb !== 2'b10) begin bad++; $display("FAIL start_done_ready_busy: got %b want 10", rb); end
    total++; if (again !== 1'b0) begin bad++; $display("FAIL start_done_width: got %b want 0", again); end
    total++; if ({scl_t, sda_t} !== 2'b00) begin bad++; $display("FAIL start_bus_hold: got %b want 00", {scl_t, sda_t}); end
    run_cmd(CMD_STOP, 8'h00, 1'b1, 9'h1FF, 0, 0, lat, again, mid, rb);
    total++; if (lat != 4*Q) begin bad++; $display("FAIL stop_latency: got %0d want %0d", lat, 4*Q); end
    total++; if (stop_cnt - stop_base != 1) begin bad++; $display("FAIL stop_condition: got %0d want 1", stop_cnt - stop_base); end
    total++; if ({scl_t, sda_t} !== 2'b11) begin bad++; $display("FAIL stop_lines: got %b want 11", {scl_t, sda_t}); end
  endtask

  task automatic test_write();
    int lat; logic again; logic [7:0] mid; logic [1:0] rb;
    logic [7:0] b; logic ack; logic [8:0] tv, got_line, got_mst;
    run_cmd(CMD_START, 8'h00, 1'b1, 9'h1FF, 0, 0, lat, again, mid, rb);
    for (int i = 0; i < 6; i++) begin
      b   = (i < 2) ? 8'hA5 : 8'($urandom);
      ack = (i == 0) ? 1'b0 : ((i == 1 || i == 5) ? 1'b1 : 1'($urandom));
      tv = 9'h1FF; tv[8] = ack;
      run_cmd(CMD_WRITE, b, 1'($urandom), tv, 0, 0, lat, again, mid, rb);
      for (int k = 0; k < 9; k++) begin
        got_line[8-k] = mon_line[(rise_base + k) % 1024];
        got_mst[8-k]  = mon_mst[(rise_base + k) % 1024];
      end
      total++; if (lat != 36*Q) begin bad++; $display("FAIL write_latency[%0d]: got %0d want %0d", i, lat, 36*Q); end
      total++; if (rise_cnt - rise_base != 9) begin bad++; $display("FAIL write_scl_pulses[%0d]: got %0d want 9", i, rise_cnt - rise_base); end
      total++; if (got_line !== {b, ack}) begin bad++; $display("FAIL write_bus_bits[%0d]: got %h want %h", i, got_line, {b, ack}); end
      total++; if (got_mst !== {b, 1'b1}) begin bad++; $display("FAIL write_master_sda[%0d]: got %h want %h", i, got_mst, {b, 1'b1}); end
      total++; if (ack_err !== ack) begin bad++; $display("FAIL write_ack_err[%0d]: got %b want %b", i, ack_err, ack); end
      total++; if ((start_cnt - start_base) + (stop_cnt - stop_base) != 0) begin
        bad++; $display("FAIL write_sda_stable[%0d]: got %0d events want 0", i, (start_cnt - start_base) + (stop_cnt - stop_base));
      end
    end
    run_cmd(CMD_START, 8'h00, 1'b1, 9'h1FF, 0, 0, lat, again, mid, rb);
    total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL start_clears_ack_err: got %b want 0", ack_err); end
    run_cmd(CMD_STOP, 8'h00, 1'b1, 9'h1FF, 0, 0, lat, again, mid, rb);
  endtask

  task automatic test_read();
    int lat; logic again; logic [7:0] mid; logic [1:0] rb;
    logic [7:0] b; logic rack; logic [8:0] tv, got_line, got_mst;
    run_cmd(CMD_START, 8'h00, 1'b1, 9'h1FF, 0, 0, lat, again, mid, rb);
    for (int i = 0; i < 5; i++) begin
      b    = (i < 2) ? 8'h3C : 8'($urandom);
      rack = (i == 0) ? 1'b1 : ((i == 1) ? 1'b0 : 1'($urandom));
      tv = 9'h1FF;
      for (int k = 0; k < 8; k++) tv[k] = b[7-k];
      run_cmd(CMD_READ, 8'($urandom), rack, tv, 0, 0, lat, again, mid, rb);
      for (int k = 0; k < 9; k++) begin
        got_line[8-k] = mon_line[(rise_base + k) % 1024];
        got_mst[8-k]  = mon_mst[(rise_base + k) % 1024];
      end
      total++; if (lat != 36*Q) begin bad++; $display("FAIL read_latency[%0d]: got %0d want %0d", i, lat, 36*Q); end
      total++; if (got_mst !== {8'hFF, rack}) begin bad++; $display("FAIL read_master_sda[%0d]: got %h want %h", i, got_mst, {8'hFF, rack}); end
      total++; if (got_line !== {b, rack}) begin bad++; $display("FAIL read_bus_bits[%0d]: got %h want %h", i, got_line, {b, rack}); end
      total++; if (mid !== exp_rd) begin bad++; $display("FAIL read_rd_data_early[%0d]: got %h want %h", i, mid, exp_rd); end
      total++; if (rd_data !== b) begin bad++; $display("FAIL read_rd_data[%0d]: got %h want %h", i, rd_data, b); end
      exp_rd = b;
    end
    run_cmd(CMD_STOP, 8'h00, 1'b1, 9'h1FF, 0, 0, lat, again, mid, rb);
  endtask

  task automatic test_stretch();
    int lat; logic again; logic [7:0] mid; logic [1:0] rb;
    logic [7:0] b; logic [8:0] tv, got_line;
    run_cmd(CMD_START, 8'h00, 1'b1, 9'h1FF, 0, 0, lat, again, mid, rb);
    b = 8'($urandom);
    tv = 9'h1FF; tv[8] = 1'b0;
    // Slot 3 phase 1 covers cycles 3*16+5 .. 3*16+8 after accept.
    run_cmd(CMD_WRITE, b, 1'b1, tv, 3*4*Q + Q, 20, lat, again, mid, rb);
    for (int k = 0; k < 9; k++) got_line[8-k] = mon_line[(rise_base + k) % 1024];
    total++; if (lat != 36*Q + 20) begin bad++; $display("FAIL stretch_latency: got %0d want %0d", lat, 36*Q + 20); end
    total++; if (got_line !== {b, 1'b0}) begin bad++; $display("FAIL stretch_bus_bits: got %h want %h", got_line, {b, 1'b0}); end
    total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL stretch_ack_err: got %b want 0", ack_err); end
    run_cmd(CMD_STOP, 8'h00, 1'b1, 9'h1FF, 0, 0, lat, again, mid, rb);
  endtask

  task automatic test_reset_mid();
    int lat, seen; logic again; logic [7:0] mid; logic [1:0] rb;
    run_cmd(CMD_START, 8'h00, 1'b1, 9'h1FF, 0, 0, lat, again, mid, rb);
    @(posedge CLK); #1;
    cmd_valid = 1'b1; cmd = CMD_WRITE; wr_data = 8'($urandom);
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    repeat (49) @(posedge CLK);
    #1 rst = 1'b0;
    @(posedge CLK); #1;
    total++; if ({scl_t, sda_t} !== 2'b11) begin bad++; $display("FAIL midreset_lines: got %b want 11", {scl_t, sda_t}); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midreset_cmd_ready: got %b want 1", cmd_ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midreset_done: got %b want 0", done); end
    rst = 1'b1;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (done !== 1'b0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midreset_no_done: got %0d pulses want 0", seen); end
    exp_rd = 8'h00;
    run_cmd(CMD_START, 8'h00, 1'b1, 9'h1FF, 0, 0, lat, again, mid, rb);
    total++; if (lat != 4*Q) begin bad++; $display("FAIL midreset_start_latency: got %0d want %0d", lat, 4*Q); end
    total++; if (start_cnt - start_base != 1) begin bad++; $display("FAIL midreset_start_cond: got %0d want 1", start_cnt - start_base); end
    run_cmd(CMD_STOP, 8'h00, 1'b1, 9'h1FF, 0, 0, lat, again, mid, rb);
  endtask

  task automatic test_back_to_back();
    int lat, d1, d2, rdy_bad; logic again; logic [7:0] mid; logic [1:0] rb;
    logic [7:0] b; logic ack; logic [8:0] got_line;
    b = 8'($urandom); ack = 1'($urandom);
    @(posedge CLK); #1;
    cmd_valid = 1'b1; cmd = CMD_START;
    @(posedge CLK); #1;
    // Held WRITE request must be ignored until START completes, then taken in the done cycle.
    cmd = CMD_WRITE; wr_data = b; rd_ack_n = 1'b0;
    d1 = -1; d2 = -1; rdy_bad = 0;
    for (int n = 1; n <= 400; n++) begin
      @(posedge CLK); #1;
      if (d1 > 0 && n == d1 + 1) begin
        cmd_valid = 1'b0;
        fall_base = fall_cnt; rise_base = rise_cnt; start_base = start_cnt; stop_base = stop_cnt;
        tgt_v = 9'h1FF; tgt_v[8] = ack;
      end
      @(negedge CLK);
      if (d1 < 0 && done !== 1'b1 && cmd_ready !== 1'b0) rdy_bad++;
      if (done === 1'b1) begin
        if (d1 < 0) d1 = n;
        else begin d2 = n; break; end
      end
    end
    #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 9; k++) got_line[8-k] = mon_line[(rise_base + k) % 1024];
    tgt_v = 9'h1FF;
    total++; if (rdy_bad != 0) begin bad++; $display("FAIL b2b_ready_while_busy: got %0d cycles want 0", rdy_bad); end
    total++; if (d1 != 4*Q) begin bad++; $display("FAIL b2b_start_done: got %0d want %0d", d1, 4*Q); end
    total++; if (d2 != 4*Q + 1 + 36*Q) begin bad++; $display("FAIL b2b_write_done: got %0d want %0d", d2, 4*Q + 1 + 36*Q); end
    total++; if (got_line !== {b, ack}) begin bad++; $display("FAIL b2b_bus_bits: got %h want %h", got_line, {b, ack}); end
    total++; if (ack_err !== ack) begin bad++; $display("FAIL b2b_ack_err: got %b want %b", ack_err, ack); end
    run_cmd(CMD_STOP, 8'h00, 1'b1, 9'h1FF, 0, 0, lat, again, mid, rb);
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd = 2'b00; wr_data = 8'h00; rd_ack_n = 1'b1;
    stretch = 1'b0; tgt_v = 9'h1FF; exp_rd = 8'h00;
    fall_base = 0; rise_base = 0; start_base = 0; stop_base = 0;
    test_reset();
    test_start_stop();
    test_write();
    test_read();
    test_stretch();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
